readout_ctrl: RTL and testbench

// Host-command sequencer for the 64-bit event FIFO between the sampler core and the readout path.

---
 rtl/readout_ctrl.sv | 173 +++++++++++++++++
 tb/tb_readout_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_ctrl.sv
// Host-command sequencer on the read side of the 64-bit event FIFO.
// Decodes toggle-strobed commands to arm/disarm capture, flush the FIFO or step through stored words as 32-bit halves.
module readout_ctrl #(
  parameter int WCNT_W     = 16,
  parameter bit ARM_ON_RST = 1'b0
) (
  input  logic              clk_125,
  input  logic              rst,
  input  logic [7:0]        cmd,
  input  logic [63:0]       dout_i,
  input  logic              empty_i,
  input  logic              full_i,
  output logic              rd_en_o,
  output logic              capture_en_o,
  output logic [31:0]       event_half_o,
  output logic [WCNT_W-1:0] words_o,
  output logic [7:0]        status_o
);

  // state | meaning
  // IDLE  | waiting for a new command toggle
  // FETCH | FIFO read issued for NEXT
  // LATCH | FIFO data valid, capture the word
  // FLUSH | draining FIFO until empty
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_FLUSH} state_t;

  localparam logic [6:0] OP_ARM    = 7'h01;
  localparam logic [6:0] OP_NEXT   = 7'h02;
  localparam logic [6:0] OP_FLUSH  = 7'h03;
  localparam logic [6:0] OP_DISARM = 7'h04;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cmd_q;
  logic                r_armed, w_armed_nxt;
  logic [WCNT_W-1:0]   r_words, w_words_nxt, w_words_inc;
  logic                r_ovf, w_ovf_nxt;
  logic                r_err, w_err_nxt;
  logic                r_hv, w_hv_nxt;
  logic                r_hs, w_hs_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_strobe, w_strobe_nxt;
  logic [63:0]         r_hold, w_hold_nxt;
  logic [31:0]         r_half, w_half_nxt;
  logic                w_toggle;

  // Free-running so that it tracks cmd throughout reset; no spurious command on release.
  always_ff @(posedge clk_125) begin
    r_cmd_q <= cmd;
  end

  assign w_toggle     = cmd[7] ^ r_cmd_q[7];
  assign w_words_inc  = (&r_words) ? r_words : r_words + WCNT_W'(1);
  assign rd_en_o      = ((r_state == S_FETCH) || (r_state == S_FLUSH)) && !empty_i;
  assign capture_en_o = r_armed && (r_state != S_FLUSH);
  assign event_half_o = r_half;
  assign words_o      = r_words;
  assign status_o     = {r_ack, r_err, r_ovf, empty_i, r_hs, r_hv, (r_state != S_IDLE), r_armed};

  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_armed  <= ARM_ON_RST;
      r_words  <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_hv     <= 1'b0;
      r_hs     <= 1'b0;
      r_ack    <= 1'b0;
      r_strobe <= 1'b0;
      r_hold   <= '0;
      r_half   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_armed  <= w_armed_nxt;
      r_words  <= w_words_nxt;
      r_ovf    <= w_ovf_nxt;
      r_err    <= w_err_nxt;
      r_hv     <= w_hv_nxt;
      r_hs     <= w_hs_nxt;
      r_ack    <= w_ack_nxt;
      r_strobe <= w_strobe_nxt;
      r_hold   <= w_hold_nxt;
      r_half   <= w_half_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_armed_nxt  = r_armed;
    w_words_nxt  = r_words;
    w_ovf_nxt    = r_ovf;
    w_err_nxt    = r_err;
    w_hv_nxt     = r_hv;
    w_hs_nxt     = r_hs;
    w_ack_nxt    = r_ack;
    w_strobe_nxt = r_strobe;
    w_hold_nxt   = r_hold;
    w_half_nxt   = r_half;

    if (w_toggle && (r_state != S_IDLE)) w_err_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_toggle) begin
          w_strobe_nxt = cmd[7];
          case (cmd[6:0])
            OP_ARM: begin
              w_armed_nxt = 1'b1;
              w_words_nxt = '0;
              w_ovf_nxt   = 1'b0;
              w_err_nxt   = 1'b0;
              w_hv_nxt    = 1'b0;
              w_ack_nxt   = cmd[7];
            end
            OP_DISARM: begin
              w_armed_nxt = 1'b0;
              w_ack_nxt   = cmd[7];
            end
            OP_NEXT: begin
              if (r_hv && !r_hs) begin
                w_half_nxt = r_hold[63:32];
                w_hs_nxt   = 1'b1;
                w_ack_nxt  = cmd[7];
              end else if (!empty_i) begin
                w_state_nxt = S_FETCH;
              end else begin
                w_hv_nxt  = 1'b0;
                w_ack_nxt = cmd[7];
              end
            end
            OP_FLUSH: w_state_nxt = S_FLUSH;
            default: begin
              w_err_nxt = 1'b1;
              w_ack_nxt = cmd[7];
            end
          endcase
        end
      end
      S_FETCH: begin
        // FIFO emptied under us: no read was issued, report nothing to show.
        if (empty_i) begin
          w_hv_nxt    = 1'b0;
          w_ack_nxt   = r_strobe;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_hold_nxt  = dout_i;
        w_half_nxt  = dout_i[31:0];
        w_hv_nxt    = 1'b1;
        w_hs_nxt    = 1'b0;
        w_words_nxt = w_words_inc;
        w_ack_nxt   = r_strobe;
        w_state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (!empty_i) begin
          w_words_nxt = w_words_inc;
        end else begin
          w_hv_nxt    = 1'b0;
          w_ack_nxt   = r_strobe;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (capture_en_o && full_i) w_ovf_nxt = 1'b1;
  end

endmodule

// File: tb/tb_readout_ctrl.sv
// Bench for readout_ctrl: directed vector table, corner sequences, and random commands
// checked against a transaction-level model of the FIFO and the command rules.
module tb_readout_ctrl;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cmd;
  logic [63:0]   dout_i;
  logic          empty_i;
  logic          full_i;
  logic          rd_en_o;
  logic          capture_en_o;
  logic [31:0]   event_half_o;
  logic [W-1:0]  words_o;
  logic [7:0]    status_o;

  int errors = 0;
  int checks = 0;
  logic strobe = 1'b0;

  always #4 clk = ~clk;

  readout_ctrl #(.WCNT_W(W), .ARM_ON_RST(1'b0)) dut (
    .clk_125(clk), .rst(rst), .cmd(cmd), .dout_i(dout_i), .empty_i(empty_i),
    .full_i(full_i), .rd_en_o(rd_en_o), .capture_en_o(capture_en_o),
    .event_half_o(event_half_o), .words_o(words_o), .status_o(status_o)
  );

  // Standard (non-FWFT) FIFO: data appears the cycle after rd_en_o.
  logic [63:0] mem [0:63];
  logic [5:0]  wp, rp;
  int          cnt;
  logic        push;
  logic [63:0] push_d;
  int          rd_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; cnt <= 0; dout_i <= '0;
    end else begin
      if (rd_en_o) begin
        dout_i <= mem[rp];
        rp <= rp + 6'd1;
      end
      if (push) begin
        mem[wp] <= push_d;
        wp <= wp + 6'd1;
      end
      cnt <= cnt + (push ? 1 : 0) - (rd_en_o ? 1 : 0);
    end
  end
  assign empty_i = (cnt == 0);

  always @(posedge clk) if (rd_en_o) rd_cnt <= rd_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push = 1'b1;
      push_d = base + 64'(i);
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic send(input logic [6:0] op);
    @(negedge clk);
    strobe = ~strobe;
    cmd = {strobe, op};
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((status_o[7] == strobe) && !status_o[1]) && n < 200);
    chk("ack_timeout", 64'(n < 200), 64'd1);
  endtask

  typedef struct {
    logic [6:0]  op;
    int          npush;
    logic [63:0] pdata;
    logic [31:0] half;
    logic [3:0]  words;
    logic        cap;
    logic [6:0]  st;
    int          rd;
  } vec_t;

  vec_t tbl [8];

  // Transaction-level reference for the random phase.
  logic        m_armed, m_err, m_hv, m_hs;
  int          m_words;
  logic [63:0] m_hold;
  logic [31:0] m_half;
  logic [63:0] mq [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    logic s_flush;

    tbl[0] = '{7'h01, 0, 64'h0,                  32'h0,         4'd0, 1'b1, 7'h11, 0};
    tbl[1] = '{7'h02, 1, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, 4'd1, 1'b1, 7'h15, 1};
    tbl[2] = '{7'h02, 0, 64'h0,                  32'hAAAA_BBBB, 4'd1, 1'b1, 7'h1D, 0};
    tbl[3] = '{7'h02, 0, 64'h0,                  32'hAAAA_BBBB, 4'd1, 1'b1, 7'h19, 0};
    tbl[4] = '{7'h03, 5, 64'h1000,               32'hAAAA_BBBB, 4'd6, 1'b1, 7'h19, 5};
    tbl[5] = '{7'h7F, 0, 64'h0,                  32'hAAAA_BBBB, 4'd6, 1'b1, 7'h59, 0};
    tbl[6] = '{7'h04, 0, 64'h0,                  32'hAAAA_BBBB, 4'd6, 1'b0, 7'h58, 0};
    tbl[7] = '{7'h01, 0, 64'h0,                  32'hAAAA_BBBB, 4'd0, 1'b1, 7'h19, 0};

    rst = 1'b0; cmd = 8'h00; push = 1'b0; push_d = '0; full_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cap", 64'(capture_en_o), 64'd0);
    chk("rst_status", 64'(status_o), 64'h10);
    chk("rst_words", 64'(words_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].npush > 0) push_words(tbl[i].npush, tbl[i].pdata);
      rd0 = rd_cnt;
      send(tbl[i].op);
      wait_ack();
      chk($sformatf("vec%0d_half", i), 64'(event_half_o), 64'(tbl[i].half));
      chk($sformatf("vec%0d_words", i), 64'(words_o), 64'(tbl[i].words));
      chk($sformatf("vec%0d_cap", i), 64'(capture_en_o), 64'(tbl[i].cap));
      chk($sformatf("vec%0d_status", i), 64'(status_o), 64'({strobe, tbl[i].st}));
      chk($sformatf("vec%0d_rd", i), 64'(rd_cnt - rd0), 64'(tbl[i].rd));
    end

    // Flush of 20 words: capture gated off meanwhile, counter saturates at 15.
    push_words(20, 64'h2000);
    rd0 = rd_cnt;
    send(7'h03);
    @(negedge clk);
    chk("flush_cap_low", 64'(capture_en_o), 64'd0);
    chk("flush_busy", 64'(status_o[1]), 64'd1);
    wait_ack();
    chk("flush_rd", 64'(rd_cnt - rd0), 64'd20);
    chk("flush_sat_words", 64'(words_o), 64'd15);
    chk("flush_cap_restored", 64'(capture_en_o), 64'd1);

    // A toggle during FLUSH is dropped and flags cmd_err.
    push_words(6, 64'h3000);
    rd0 = rd_cnt;
    send(7'h03);
    s_flush = strobe;
    @(negedge clk);
    @(negedge clk);
    strobe = ~strobe;
    cmd = {strobe, 7'h01};
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (status_o[1] && n < 200);
      chk("drop_timeout", 64'(n < 200), 64'd1);
    end
    repeat (2) @(negedge clk);
    chk("drop_err", 64'(status_o[6]), 64'd1);
    chk("drop_ack", 64'(status_o[7]), 64'(s_flush));
    chk("drop_rd", 64'(rd_cnt - rd0), 64'd6);
    chk("drop_busy", 64'(status_o[1]), 64'd0);
    send(7'h01);
    wait_ack();
    chk("arm_clears", 64'(status_o), 64'({strobe, 7'h19}));

    // Overflow is sticky until the next ARM.
    @(negedge clk);
    full_i = 1'b1;
    @(negedge clk);
    full_i = 1'b0;
    chk("ovf_set", 64'(status_o[5]), 64'd1);
    repeat (3) @(negedge clk);
    send(7'h04);
    wait_ack();
    chk("ovf_sticky", 64'(status_o[5]), 64'd1);
    send(7'h01);
    wait_ack();
    chk("ovf_cleared", 64'(status_o[5]), 64'd0);

    // Random phase from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_status", 64'(status_o), 64'h10);
    m_armed = 1'b0; m_err = 1'b0; m_hv = 1'b0; m_hs = 1'b0;
    m_words = 0; m_hold = '0; m_half = '0;
    mq.delete();

    for (int it = 0; it < 60; it++) begin
      int n, r, exp_rd;
      logic [6:0] op;
      logic [63:0] d;
      n = (mq.size() > 50) ? 0 : int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin
        d = {$urandom, $urandom};
        mq.push_back(d);
        @(negedge clk);
        push = 1'b1;
        push_d = d;
      end
      if (n > 0) begin
        @(negedge clk);
        push = 1'b0;
      end
      r = int'($urandom_range(0, 9));
      if (r < 2) op = 7'h01;
      else if (r < 6) op = 7'h02;
      else if (r == 6) op = 7'h03;
      else if (r == 7) op = 7'h04;
      else if (r == 8) op = 7'($urandom_range(5, 127));
      else op = 7'h00;

      exp_rd = 0;
      case (op)
        7'h01: begin m_armed = 1'b1; m_words = 0; m_err = 1'b0; m_hv = 1'b0; end
        7'h04: m_armed = 1'b0;
        7'h02: begin
          if (m_hv && !m_hs) begin
            m_half = m_hold[63:32];
            m_hs = 1'b1;
          end else if (mq.size() > 0) begin
            m_hold = mq.pop_front();
            m_half = m_hold[31:0];
            m_hv = 1'b1;
            m_hs = 1'b0;
            m_words = (m_words + 1 > 15) ? 15 : m_words + 1;
            exp_rd = 1;
          end else begin
            m_hv = 1'b0;
          end
        end
        7'h03: begin
          exp_rd = mq.size();
          m_words = (m_words + exp_rd > 15) ? 15 : m_words + exp_rd;
          mq.delete();
          m_hv = 1'b0;
        end
        default: m_err = 1'b1;
      endcase

      rd0 = rd_cnt;
      send(op);
      wait_ack();
      chk($sformatf("rnd%0d_half", it), 64'(event_half_o), 64'(m_half));
      chk($sformatf("rnd%0d_words", it), 64'(words_o), 64'(m_words));
      chk($sformatf("rnd%0d_cap", it), 64'(capture_en_o), 64'(m_armed));
      chk($sformatf("rnd%0d_status", it), 64'(status_o),
          64'({strobe, m_err, 1'b0, (mq.size() == 0), m_hs, m_hv, 1'b0, m_armed}));
      chk($sformatf("rnd%0d_rd", it), 64'(rd_cnt - rd0), 64'(exp_rd));
    end

    // Reset asserted mid-FLUSH drops rd_en_o without waiting for a clock.
    push_words(10, 64'h4000);
    send(7'h03);
    repeat (3) @(negedge clk);
    chk("midflush_rd_active", 64'(rd_en_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("midflush_rd_drop", 64'(rd_en_o), 64'd0);
    chk("midflush_idle", 64'(status_o[1]), 64'd0);
    chk("midflush_cap", 64'(capture_en_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
